hawk_att_lkup: RTL and testbench

- Translation front end between the CPU-side request path and hawk_axird_master.
- Takes one ATT lookup per host physical page (att_lkup_reqpkt_t) and computes the ATT entry address.
- Fetches the 64B cacheline holding the entry over AXI read, extracts and decodes the AttEntry.
- Returns a trnsl_reqpkt_t (ppa, status, allow_access, zpd update) to the control unit; one lookup outstanding at a time.

---
 rtl/hawk_att_lkup_pkg.sv | 74 +++++++
 rtl/hawk_att_entry_decode.sv | 22 ++
 rtl/hawk_att_lkup.sv | 106 ++++++++++
 tb/tb_hawk_att_lkup.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hawk_att_lkup_pkg.sv
// hawk_att_lkup_pkg: shared types, constants and helpers for the ATT lookup front end
package hawk_att_lkup_pkg;
    localparam int ADDR_WIDTH = 40;
    localparam int PPN_WIDTH = ADDR_WIDTH - 12;
    localparam int ATT_ENTRY_MAX = 65536;
    localparam int IDX_WIDTH = $clog2(ATT_ENTRY_MAX);
    localparam int LINE_BITS = 512;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] STS_DALLOC = 2'b00;
    localparam logic [1:0] STS_UNCOMP = 2'b01;
    localparam logic [1:0] STS_COMP = 2'b10;
    localparam logic [1:0] STS_INCOMP = 2'b11;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} hawk_att_lkup_state_t;

    typedef struct packed {
        logic [63-PPN_WIDTH-10:0] rsvd;
        logic [7:0] zpd_cnt;
        logic [PPN_WIDTH-1:0] way;
        logic [1:0] sts;
    } att_entry_t;

    typedef struct packed {
        logic lookup;
        logic [PPN_WIDTH-1:0] hppa;
        logic zero_blk_wr;
    } att_lkup_reqpkt_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] ppa;
        logic [1:0] sts;
        logic allow_access;
        logic zpd_update;
        logic [7:0] zpd_cnt;
    } trnsl_reqpkt_t;

    typedef struct packed {
        logic arvalid;
        logic [ADDR_WIDTH-1:0] araddr;
        logic [7:0] arlen;
        logic rready;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic arready;
    } axi_rd_rdypkt_t;

    typedef struct packed {
        logic [LINE_BITS-1:0] rdata;
        logic [1:0] rresp;
        logic rvalid;
        logic rlast;
    } axi_rd_resppkt_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] line;
        logic [2:0] slot;
    } att_line_t;

    function automatic logic [LINE_BITS-1:0] get_8byte_byteswap(input logic [LINE_BITS-1:0] d);
        logic [LINE_BITS-1:0] r;
        for (int w = 0; w < LINE_BITS / 64; w++)
            for (int b = 0; b < 8; b++)
                r[64*w+8*b +: 8] = d[64*w+8*(7-b) +: 8];
        return r;
    endfunction

    function automatic att_line_t att_entry_line_addr(input logic [IDX_WIDTH-1:0] idx,
                                                      input logic [ADDR_WIDTH-1:0] att_start);
        logic [ADDR_WIDTH-1:0] ea;
        ea = att_start + (ADDR_WIDTH'(idx) << 3);
        return '{line: {ea[ADDR_WIDTH-1:6], 6'b0}, slot: idx[2:0]};
    endfunction
endpackage

// File: rtl/hawk_att_entry_decode.sv
// hawk_att_entry_decode: turns a fetched ATT entry into a translation result
module hawk_att_entry_decode
    import hawk_att_lkup_pkg::*;
(
    input  att_entry_t    entry,
    input  logic          zero_blk_wr,
    input  logic [1:0]    rresp,
    output trnsl_reqpkt_t trnsl,
    output logic          err
);
    logic uncomp, bump, unused_rsvd;
    assign unused_rsvd = ^entry.rsvd;
    assign err = rresp != AXI_RESP_OKAY;
    assign uncomp = entry.sts == STS_UNCOMP;
    assign bump = zero_blk_wr && uncomp && !err;
    assign trnsl.ppa = {entry.way, 12'h0};
    assign trnsl.sts = entry.sts;
    assign trnsl.allow_access = uncomp && !err;
    assign trnsl.zpd_update = bump;
    // zero-page count saturates rather than wrapping
    assign trnsl.zpd_cnt = bump && entry.zpd_cnt != 8'hff ? entry.zpd_cnt + 8'd1 : entry.zpd_cnt;
endmodule

// File: rtl/hawk_att_lkup.sv
// hawk_att_lkup: fetches and decodes one ATT entry per host page over AXI read
module hawk_att_lkup
    import hawk_att_lkup_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] ATT_START = 40'hFF_F610_0000,
    parameter logic [ADDR_WIDTH-1:0] HPPA_BASE = 40'hFF_F640_0000,
    parameter int unsigned ENTRY_CNT = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  att_lkup_reqpkt_t lkup_req_i,
    output logic             lkup_ready_o,
    output axi_rd_reqpkt_t   rd_req_o,
    input  axi_rd_rdypkt_t   rd_rdy_i,
    input  axi_rd_resppkt_t  rd_resp_i,
    output trnsl_reqpkt_t    trnsl_o,
    output logic             trnsl_valid_o,
    input  logic             trnsl_ready_i,
    output logic             lkup_err_o,
    output logic             busy_o
);
    hawk_att_lkup_state_t state, state_nxt;
    logic [IDX_WIDTH-1:0] idx, idx_q;
    logic zbw_q, got_q, accept, beat, done, illegal, dec_err;
    logic [1:0] rresp_q;
    logic [LINE_BITS-1:0] swapped;
    att_entry_t ent_q, beat_ent;
    att_line_t loc;
    trnsl_reqpkt_t dec_trnsl;

    assign idx = IDX_WIDTH'(lkup_req_i.hppa - HPPA_BASE[ADDR_WIDTH-1:12]);
    assign illegal = 32'(idx) >= ENTRY_CNT;
    assign loc = att_entry_line_addr(idx_q, ATT_START);
    assign swapped = get_8byte_byteswap(rd_resp_i.rdata);
    assign beat_ent = swapped[{loc.slot, 6'b0} +: 64];
    assign accept = state == IDLE && lkup_req_i.lookup;
    assign beat = state == DATA && rd_resp_i.rvalid;
    assign done = beat && rd_resp_i.rlast;

    // the first beat is decoded directly so a single-beat burst exits in its own cycle
    hawk_att_entry_decode u_dec (
        .entry       (got_q ? ent_q : beat_ent),
        .zero_blk_wr (zbw_q),
        .rresp       (got_q ? rresp_q : rd_resp_i.rresp),
        .trnsl       (dec_trnsl),
        .err         (dec_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = illegal ? RESP : ADDR;
            ADDR: if (rd_rdy_i.arready) state_nxt = DATA;
            DATA: if (done) state_nxt = RESP;
            RESP: if (trnsl_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lkup_ready_o = state == IDLE;
        busy_o = state != IDLE;
        trnsl_valid_o = state == RESP;
        rd_req_o = '0;
        rd_req_o.arvalid = state == ADDR;
        rd_req_o.araddr = state == ADDR ? loc.line : '0;
        rd_req_o.rready = state == DATA;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
            zbw_q <= 1'b0;
            got_q <= 1'b0;
            ent_q <= '0;
            rresp_q <= '0;
            trnsl_o <= '0;
            lkup_err_o <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= idx;
                zbw_q <= lkup_req_i.zero_blk_wr;
                got_q <= 1'b0;
            end
            if (beat && !got_q) begin
                ent_q <= beat_ent;
                rresp_q <= rd_resp_i.rresp;
                got_q <= 1'b1;
            end
            if (accept && illegal) begin
                trnsl_o <= '{ppa: '0, sts: STS_DALLOC, allow_access: 1'b0, zpd_update: 1'b0, zpd_cnt: '0};
                lkup_err_o <= 1'b1;
            end else if (done) begin
                trnsl_o <= dec_trnsl;
                lkup_err_o <= dec_err;
            end else if (state == RESP && trnsl_ready_i) begin
                trnsl_o <= '0;
                lkup_err_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hawk_att_lkup.sv
// tb_hawk_att_lkup: scoreboard bench for hawk_att_lkup against an ATT table model
module tb_hawk_att_lkup;
    import hawk_att_lkup_pkg::*;
    localparam logic [ADDR_WIDTH-1:0] ATT = 40'hFF_F610_0000;
    localparam logic [ADDR_WIDTH-1:0] HB = 40'hFF_F640_0000;
    localparam logic [PPN_WIDTH-1:0] HB_PG = 28'hFFF6400;
    localparam int CNT = 24;

    logic clk = 0, rst_n = 0;
    att_lkup_reqpkt_t lkup_req = '0;
    axi_rd_rdypkt_t rd_rdy = '0;
    axi_rd_resppkt_t rd_resp = '0;
    axi_rd_reqpkt_t rd_req;
    trnsl_reqpkt_t trnsl;
    logic lkup_ready, trnsl_valid, lkup_err, busy;
    logic trnsl_ready = 0;
    int checks = 0, failures = 0, cyc = 0;

    typedef struct {
        trnsl_reqpkt_t t;
        logic err;
        logic legal;
        int lat;
        int acc;
        int stall;
    } exp_t;
    exp_t exp_q[$];

    logic [PPN_WIDTH-1:0] way_m[32];
    logic [7:0] zpd_m[32];
    logic [1:0] sts_m[32];

    hawk_att_lkup #(.ATT_START(ATT), .HPPA_BASE(HB), .ENTRY_CNT(CNT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .lkup_req_i(lkup_req), .lkup_ready_o(lkup_ready),
        .rd_req_o(rd_req), .rd_rdy_i(rd_rdy), .rd_resp_i(rd_resp), .trnsl_o(trnsl),
        .trnsl_valid_o(trnsl_valid), .trnsl_ready_i(trnsl_ready), .lkup_err_o(lkup_err), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic die(input string name);
        failures++;
        $display("FAIL %s: wait bound expired", name);
        $fatal(1, "bench stopped");
    endtask

    function automatic int idx_of(input logic [PPN_WIDTH-1:0] hppa);
        return int'(hppa - HB_PG) & 32'hFFFF;
    endfunction

    function automatic exp_t model(input logic [PPN_WIDTH-1:0] hppa, input logic zbw, input logic [1:0] rresp);
        exp_t e;
        int i, z;
        i = idx_of(hppa);
        e.t = '0;
        e.acc = 0;
        e.stall = 0;
        e.legal = i < CNT;
        e.lat = 1;
        e.err = 1'b1;
        if (!e.legal) begin
            e.t.sts = STS_DALLOC;
            return e;
        end
        e.err = rresp != 2'b00;
        e.t.ppa = {way_m[i], 12'h0};
        e.t.sts = sts_m[i];
        e.t.allow_access = !e.err && sts_m[i] == STS_UNCOMP;
        e.t.zpd_update = e.t.allow_access && zbw;
        z = int'(zpd_m[i]) + (e.t.zpd_update ? 1 : 0);
        e.t.zpd_cnt = 8'(z > 255 ? 255 : z);
        return e;
    endfunction

    // memory holds each 8-byte entry big-endian; bus byte k is memory byte line+k
    function automatic logic [LINE_BITS-1:0] line_image(input int li);
        logic [LINE_BITS-1:0] d;
        att_entry_t e;
        for (int w = 0; w < 8; w++) begin
            e = '{rsvd: 26'h2AA_AAAA, zpd_cnt: zpd_m[li*8+w], way: way_m[li*8+w], sts: sts_m[li*8+w]};
            for (int k = 0; k < 8; k++) d[8*(8*w+k) +: 8] = e[8*(7-k) +: 8];
        end
        return d;
    endfunction

    task automatic wait_idle(input string name);
        for (int n = 0; !lkup_ready; n++) begin
            if (n > 200) die(name);
            @(negedge clk);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_lkup_ready"}, lkup_ready, 1);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_trnsl"}, trnsl, 0);
        chk({tag, "_valid_err_busy"}, {trnsl_valid, lkup_err, busy}, 0);
    endtask

    task automatic do_lkup(input logic [PPN_WIDTH-1:0] hppa, input logic zbw, input logic [1:0] rresp,
                           input int ar_wait, input int r_wait, input int extra, input int stall);
        exp_t e;
        int i;
        logic bad;
        logic [ADDR_WIDTH-1:0] ea, line;
        wait_idle("lkup_ready");
        e = model(hppa, zbw, rresp);
        e.acc = cyc;
        e.stall = stall;
        if (e.legal) e.lat = 3 + ar_wait + r_wait + extra;
        exp_q.push_back(e);
        lkup_req = '{lookup: 1'b1, hppa: hppa, zero_blk_wr: zbw};
        @(negedge clk);
        lkup_req = '0;
        if (!e.legal) begin
            bad = 0;
            for (int n = 0; !lkup_ready; n++) begin
                if (n > 200) die("illegal_return");
                bad = bad | rd_req.arvalid;
                @(negedge clk);
            end
            chk("no_ar_on_illegal", bad, 0);
            return;
        end
        i = idx_of(hppa);
        ea = ATT + ADDR_WIDTH'(i) * 8;
        line = ea - (ea % 64);
        for (int n = 0; ; n++) begin
            if (n > 100) die("ar_phase");
            chk("arvalid", rd_req.arvalid, 1);
            chk("araddr", rd_req.araddr, line);
            chk("arlen_rready", {rd_req.arlen, rd_req.rready}, 0);
            rd_rdy.arready = n >= ar_wait;
            rd_resp.rvalid = 1'($urandom_range(0, 1));
            rd_resp.rlast = 1'b1;
            rd_resp.rresp = 2'($urandom);
            rd_resp.rdata = {16{$urandom}};
            @(negedge clk);
            if (n >= ar_wait) break;
        end
        rd_rdy = '0;
        rd_resp = '0;
        repeat (r_wait) @(negedge clk);
        for (int b = 0; b <= extra; b++) begin
            chk("rready", rd_req.rready, 1);
            rd_resp.rvalid = 1'b1;
            rd_resp.rlast = b == extra;
            rd_resp.rdata = b == 0 ? line_image(i / 8) : {16{$urandom}};
            rd_resp.rresp = b == 0 ? rresp : 2'($urandom);
            @(negedge clk);
        end
        rd_resp = '0;
    endtask

    initial begin : monitor
        exp_t e;
        logic seen, hs;
        int cnt;
        trnsl_reqpkt_t hold;
        logic hold_err;
        seen = 0;
        hs = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
                hs = 0;
                trnsl_ready = 0;
                continue;
            end
            if (hs) chk("idle_after_handshake", {trnsl_valid, lkup_ready, busy}, 3'b010);
            hs = 0;
            if (!trnsl_valid) begin
                trnsl_ready = 0;
                continue;
            end
            chk("lkup_ready_in_resp", lkup_ready, 0);
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                    trnsl_ready = 1;
                    continue;
                end
                e = exp_q[0];
                seen = 1;
                cnt = e.stall;
                hold = trnsl;
                hold_err = lkup_err;
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end else chk("result_stable", {hold_err, hold}, {lkup_err, trnsl});
            if (cnt == 0) begin
                chk("err", lkup_err, e.err);
                chk("allow_access", trnsl.allow_access, e.t.allow_access);
                chk("sts", trnsl.sts, e.t.sts);
                if (e.legal) begin
                    chk("ppa", trnsl.ppa, e.t.ppa);
                    chk("zpd_update", trnsl.zpd_update, e.t.zpd_update);
                    chk("zpd_cnt", trnsl.zpd_cnt, e.t.zpd_cnt);
                end
                void'(exp_q.pop_front());
                seen = 0;
                hs = 1;
                trnsl_ready = 1;
            end else begin
                cnt--;
                trnsl_ready = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench stopped");
    end

    initial begin
        logic [PPN_WIDTH-1:0] hppa;
        for (int i = 0; i < 32; i++) begin
            way_m[i] = 28'($urandom);
            zpd_m[i] = 8'($urandom);
            sts_m[i] = 2'($urandom);
        end
        way_m[3] = 28'hFFF6305;
        zpd_m[3] = 8'd5;
        sts_m[3] = STS_UNCOMP;
        zpd_m[11] = 8'd255;
        sts_m[11] = STS_UNCOMP;
        sts_m[5] = STS_COMP;
        sts_m[6] = STS_UNCOMP;
        @(negedge clk);
        rst_chk("reset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_lkup(28'hFFF6403, 0, 2'b00, 0, 0, 0, 0);
        do_lkup(28'hFFF640B, 1, 2'b00, 0, 0, 0, 0);
        do_lkup(28'hFFF6418, 0, 2'b00, 0, 0, 0, 0);
        do_lkup(28'hFFF6405, 0, 2'b00, 0, 0, 0, 1);
        do_lkup(28'hFFF6406, 1, 2'b10, 0, 0, 0, 0);
        do_lkup(28'hFFF6403, 1, 2'b00, 5, 0, 0, 4);
        do_lkup(28'hFFF63FF, 0, 2'b00, 0, 0, 0, 0);
        wait_idle("pre_reset_idle");
        lkup_req = '{lookup: 1'b1, hppa: 28'hFFF6407, zero_blk_wr: 1'b0};
        @(negedge clk);
        lkup_req = '0;
        rd_rdy.arready = 1'b1;
        @(negedge clk);
        rd_rdy = '0;
        chk("in_data_before_reset", {busy, rd_req.rready}, 2'b11);
        #2 rst_n = 0;
        #1 rst_chk("mid_reset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_lkup(28'hFFF6407, 1, 2'b00, 0, 1, 1, 0);
        for (int n = 0; n < 60; n++) begin
            zpd_m[$urandom_range(0, 23)] = 8'($urandom_range(250, 255));
            sts_m[$urandom_range(0, 23)] = 2'($urandom);
            hppa = HB_PG - 28'd2 + 28'($urandom_range(0, 35));
            do_lkup(hppa, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        for (int n = 0; exp_q.size() != 0; n++) begin
            if (n > 200) die("drain");
            @(negedge clk);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
